fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/control stage. Owns the program counter and issues in-order read requests to instruction memory, which has variable latency. Buffers returned instructions with their PCs in a small FIFO and presents them downstream over a valid/ready handshake. Stops fetching after a halt opcode and supports redirect with flush of buffered and in-flight fetches.

Parameters:
ADDR_W, 16, PC / instruction address width (matches `RegWidth)
INSTR_W, 16, instruction width (matches `InstrWidth)
OP_W, 4, opcode field width, taken from the instruction MSBs (matches `OpWidth)
HALT_OP, 4'hF, opcode value treated as halt (matches `OP_HALT)
DEPTH, 4, FIFO entries; also the cap on in-flight requests; power of 2, at least 2
RESET_PC, 0, PC loaded on reset

Ports:
CLK  input  1  clock, all state updates on posedge
RST  input  1  synchronous active-high reset
mem_req  output  1  read request valid
mem_addr  output  ADDR_W  read address, valid while mem_req is high
mem_ready  input  1  memory accepts the request this cycle
mem_rvalid  input  1  read data valid; responses return in request order
mem_rdata  input  INSTR_W  returned instruction
redirect  input  1  load new PC and flush
redirect_pc  input  ADDR_W  new PC
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts the head
out_instr  output  INSTR_W  head instruction
out_pc  output  ADDR_W  address of the head instruction
halted  output  1  halt opcode has been fetched; issue is stopped

Behaviour:
- Reset (RST high at posedge): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, halted=0. During reset: mem_req=0 and out_valid=0. Reset mid-operation abandons in-flight responses. Responses with mem_rvalid high during reset are ignored.
- Issue:
  - mem_req = !RST && !halted && !redirect && (outstanding + fifo_count < DEPTH).
  - mem_addr = fetch_pc.
  - A request is accepted when mem_req && mem_ready. On acceptance, fetch_pc increments by 1 (wraps modulo 2^ADDR_W) and outstanding increments.
  - Minimum latency from issue to out_valid is one cycle after the mem_rvalid cycle.
- Response: mem_rvalid decrements outstanding.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise it is written to the FIFO as {mem_rdata, resp_pc}, and resp_pc increments.
  - If mem_rdata[INSTR_W-1 -: OP_W]==HALT_OP: halted<=1. The halt instruction itself is enqueued. All responses still in flight at that point are discarded (discard<=outstanding after this response).
- FIFO:
  - Circular buffer of DEPTH entries. out_* are driven from the head entry (registered storage).
  - Pop on out_valid && out_ready. Push and pop in the same cycle are allowed at any fill level.
  - Overflow cannot occur by construction: space is reserved at issue.
  - out_valid=0 when empty. out_instr/out_pc hold their last values when empty.
- Redirect (registered, takes priority over all else except RST):
  - fetch_pc<=redirect_pc, resp_pc<=redirect_pc, FIFO flushed, halted<=0.
  - discard<=outstanding minus 1 if a non-discarded or discarded response arrives the same cycle, plus 0 (no issue happens that cycle).
  - A pop in the same cycle is still honoured downstream, but out_valid drops the next cycle.
  - The first request to redirect_pc is issued the cycle after redirect.
- Halted state: remains until redirect or RST. The FIFO continues draining normally.
- States: RUN (issue allowed) → HALTED on a halt response. HALTED → RUN on redirect. Any state → RUN on RST. Discard is orthogonal (counter).

Test Plan:
- Memory with mem_ready=1 and fixed 1-cycle rvalid latency; mem[0..3]=1234,2345,3456,F000; out_ready=1 -> out stream (pc,instr) = (0,1234),(1,2345),(2,3456),(3,F000); halted=1 after the fourth response; no request to addr 4 is ever accepted-and-delivered.
- out_ready=0, latency 1 -> exactly 4 requests issued (addr 0..3), mem_req then stays 0. Raising out_ready drains 4 entries in 4 consecutive cycles; issue resumes at addr 4.
- Latency 3 with 3 requests in flight; redirect with redirect_pc=0x0100 -> the 3 stale responses are dropped, first out_pc=0x0100, halted cleared.
- Redirect in the same cycle as a mem_rvalid, with 2 outstanding -> 1 further response dropped. No stale instruction appears at the output.
- Halt at addr 2 with addr 3 and 4 in flight -> both dropped. The FIFO delivers addr 0..2 only. A subsequent redirect to 0x0010 resumes fetch.
- RST asserted mid-stream for 1 cycle with the FIFO half full -> next cycle out_valid=0, halted=0, first new request has mem_addr=0. A late mem_rvalid during RST is not delivered.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : In-order instruction fetch with variable-latency memory, result
//            FIFO, halt detection and redirect with in-flight discard.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                OP_W     = 4,
    parameter logic [OP_W-1:0]   HALT_OP  = 4'hF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_resp_pc;
    logic [CNT_W-1:0]     r_outstanding;
    logic [CNT_W-1:0]     r_discard;
    logic [CNT_W-1:0]     r_count;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [INSTR_W-1:0]   r_buf_instr [DEPTH];
    logic [ADDR_W-1:0]    r_buf_pc    [DEPTH];
    logic [INSTR_W-1:0]   r_out_instr;
    logic [ADDR_W-1:0]    r_out_pc;

    logic                 w_issue_ok;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_keep;
    logic                 w_is_halt;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_out_after;
    logic [CNT_W-1:0]     w_count_next;
    logic [PTR_W-1:0]     w_rd_next;

    // Slots are reserved at issue time, so in-flight plus buffered never exceeds DEPTH.
    assign w_issue_ok  = ({1'b0, r_outstanding} + {1'b0, r_count}) < C_DEPTH;
    assign mem_req     = !RST && (r_state == ST_RUN) && !redirect && w_issue_ok;
    assign mem_addr    = r_fetch_pc;
    assign w_accept    = mem_req && mem_ready;

    assign w_drop      = (r_discard != '0);
    assign w_keep      = mem_rvalid && !w_drop;
    assign w_is_halt   = (mem_rdata[INSTR_W-1 -: OP_W] == HALT_OP);
    assign w_push      = w_keep && !redirect;

    assign out_valid   = !RST && (r_count != '0);
    assign w_pop       = out_valid && out_ready;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign halted      = (r_state == ST_HALTED);

    assign w_out_after  = r_outstanding + CNT_W'(w_accept) - CNT_W'(mem_rvalid);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);

    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            w_state_next = ST_RUN;
        end else if (w_keep && w_is_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, in-flight and discard bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_after;
            if (redirect || (w_keep && w_is_halt)) begin
                r_discard <= w_out_after;
            end else if (mem_rvalid && w_drop) begin
                r_discard <= r_discard - 1'b1;
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                end
                if (w_keep) begin
                    r_resp_pc <= r_resp_pc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= mem_rdata;
            r_buf_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

    // Head copy only reloads when the FIFO stays non-empty, so it holds when drained.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (!redirect && (w_count_next != '0)) begin
            if (w_push && (r_wr_ptr == w_rd_next)) begin
                r_out_instr <= mem_rdata;
                r_out_pc    <= r_resp_pc;
            end else begin
                r_out_instr <= r_buf_instr[w_rd_next];
                r_out_pc    <= r_buf_pc[w_rd_next];
            end
        end
    end

endmodule
`default_nettype wire
